// File: rtl/segre_pkg.sv
// Shared types and default sizes for the main-memory arbiter.
package segre_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_LINE_W  = 128;
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/segre_rr_picker.sv
// Combinational rotating-priority picker: first requester at or above ptr, with wrap-around.
// A pointer tied to zero turns it into a lowest-index-wins fixed-priority picker.
module segre_rr_picker #(
    parameter int  NUM_CH = 2,
    localparam int PTR_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic              valid
);

    localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

    logic [NUM_CH-1:0] rot;
    logic [NUM_CH-1:0] rot_oh;

    // Rotate so the pointer channel sits at bit 0, isolate the lowest set bit, rotate back.
    assign rot    = NUM_CH'({req, req} >> ptr);
    assign rot_oh = rot & (~rot + ONE);
    assign gnt    = NUM_CH'(({rot_oh, rot_oh} << ptr) >> NUM_CH);
    assign valid  = |req;

endmodule

// File: rtl/segre_mem_arbiter.sv
// NUM_CH-to-1 main-memory arbiter with response routing and a response watchdog.
// Define SEGRE_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (channel 0 highest).
module segre_mem_arbiter
    import segre_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LINE_W  = DEF_LINE_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk_i,
    input  logic                     rsn_i,
    input  logic [NUM_CH-1:0]        req_i,
    input  logic [NUM_CH-1:0]        we_i,
    input  logic [NUM_CH*ADDR_W-1:0] addr_i,
    input  logic [NUM_CH*LINE_W-1:0] wdata_i,
    output logic [NUM_CH-1:0]        gnt_o,
    output logic [NUM_CH-1:0]        rvalid_o,
    output logic [LINE_W-1:0]        rdata_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [LINE_W-1:0]        mem_wdata_o,
    input  logic                     mem_rvalid_i,
    input  logic [LINE_W-1:0]        mem_rdata_i,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int PTR_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e        state_reg;
    logic [NUM_CH-1:0] owner_reg;
    logic [NUM_CH-1:0] gnt_reg;
    logic [NUM_CH-1:0] rvalid_reg;
    logic [LINE_W-1:0] rdata_reg;
    logic              mem_req_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [LINE_W-1:0] wdata_reg;
    logic [CNT_W-1:0]  wdog_reg;
    logic              err_reg;

    logic [PTR_W-1:0]  ptr;
    logic [NUM_CH-1:0] pick;
    logic              pick_valid;

    segre_rr_picker #(
        .NUM_CH (NUM_CH)
    ) u_picker (
        .req   (req_i),
        .ptr   (ptr),
        .gnt   (pick),
        .valid (pick_valid)
    );

`ifdef SEGRE_ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] win_idx;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pick[i]) win_idx = PTR_W'(i);
        end
    end

    assign ptr_next = (win_idx == PTR_W'(NUM_CH - 1)) ? '0 : win_idx + PTR_W'(1);

    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            ptr_reg <= '0;
        end else if (state_reg == IDLE && pick_valid) begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;
`else
    assign ptr = '0;
`endif

    // One-hot select of the winner's address and write data.
    logic [ADDR_W-1:0] addr_term  [NUM_CH];
    logic [LINE_W-1:0] wdata_term [NUM_CH];
    logic [ADDR_W-1:0] sel_addr;
    logic [LINE_W-1:0] sel_wdata;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sel
        assign addr_term[gi]  = pick[gi] ? addr_i[gi*ADDR_W +: ADDR_W]  : '0;
        assign wdata_term[gi] = pick[gi] ? wdata_i[gi*LINE_W +: LINE_W] : '0;
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_addr  = sel_addr | addr_term[i];
            sel_wdata = sel_wdata | wdata_term[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            state_reg   <= IDLE;
            owner_reg   <= '0;
            gnt_reg     <= '0;
            rvalid_reg  <= '0;
            rdata_reg   <= '0;
            mem_req_reg <= 1'b0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wdog_reg    <= '0;
            err_reg     <= 1'b0;
        end else begin
            gnt_reg     <= '0;
            rvalid_reg  <= '0;
            mem_req_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        owner_reg   <= pick;
                        gnt_reg     <= pick;
                        mem_req_reg <= 1'b1;
                        we_reg      <= |(we_i & pick);
                        addr_reg    <= sel_addr;
                        wdata_reg   <= sel_wdata;
                        state_reg   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A zero-latency memory may answer in the same cycle as the request.
                    if (mem_rvalid_i) begin
                        rdata_reg  <= mem_rdata_i;
                        rvalid_reg <= owner_reg;
                        state_reg  <= IDLE;
                    end else begin
                        wdog_reg  <= '0;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        rdata_reg  <= mem_rdata_i;
                        rvalid_reg <= owner_reg;
                        state_reg  <= IDLE;
                    end else if (wdog_reg == CNT_W'(TIMEOUT - 1)) begin
                        err_reg    <= 1'b1;
                        rdata_reg  <= '0;
                        rvalid_reg <= owner_reg;
                        state_reg  <= IDLE;
                    end else begin
                        wdog_reg <= wdog_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign gnt_o       = gnt_reg;
    assign rvalid_o    = rvalid_reg;
    assign rdata_o     = rdata_reg;
    assign mem_req_o   = mem_req_reg;
    assign mem_we_o    = we_reg;
    assign mem_addr_o  = addr_reg;
    assign mem_wdata_o = wdata_reg;
    assign busy_o      = (state_reg != IDLE);
    assign err_o       = err_reg;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Randomized self-checking bench for segre_mem_arbiter (4 channels, TIMEOUT=4) with a behavioural arbitration model.
module tb_segre_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 128;
    localparam int TO = 4;
`ifdef SEGRE_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rsn;
    logic [N-1:0]    req, we;
    logic [N*AW-1:0] addr;
    logic [N*LW-1:0] wdata;
    logic [N-1:0]    gnt, rvalid;
    logic [LW-1:0]   rdata;
    logic            mem_req, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [LW-1:0]   mem_wdata;
    logic            mem_rvalid;
    logic [LW-1:0]   mem_rdata;
    logic            busy, err;

    int tests = 0;
    int fails = 0;
    int model_ptr = 0;

    always #5 clk = ~clk;

    segre_mem_arbiter #(.NUM_CH(N), .ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rsn_i(rsn), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .busy_o(busy), .err_o(err)
    );

    // Reference arbitration: scan channels upward from the pointer (always 0 for fixed priority).
    function automatic int model_winner(input logic [N-1:0] r);
        int start;
        start = RR ? model_ptr : 0;
        for (int i = 0; i < N; i++) begin
            int c;
            c = (start + i) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int c);
        logic [N-1:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rsn = 1'b1; req = '0; we = '0; mem_rvalid = 1'b0;
        tick(); tick();
        rsn = 1'b0;
        model_ptr = 0;
    endtask

    task automatic set_ch(input int c, input logic w, input logic [AW-1:0] a, input logic [LW-1:0] d);
        req[c] = 1'b1;
        we[c] = w;
        addr[c*AW +: AW] = a;
        wdata[c*LW +: LW] = d;
    endtask

    // Drives one transaction from the current IDLE cycle; lat<0 means memory never answers.
    task automatic run_txn(input int lat, input logic [LW-1:0] resp,
                           output logic [N-1:0] o_gnt, output logic o_we, output logic [AW-1:0] o_addr,
                           output logic [LW-1:0] o_wdata, output logic [N-1:0] o_rvalid,
                           output logic [LW-1:0] o_rdata, output int o_wait, output int o_glitch,
                           output logic o_busy_end);
        bit done;
        o_glitch = 0; o_rvalid = '0; o_rdata = '0; o_wait = -1; o_busy_end = 1'b1; done = 1'b0;
        tick();
        o_gnt = gnt; o_we = mem_we; o_addr = mem_addr; o_wdata = mem_wdata;
        if (mem_req !== 1'b1 || busy !== 1'b1) o_glitch++;
        req = req & ~gnt;
        if (lat == 0) begin mem_rvalid = 1'b1; mem_rdata = resp; end
        for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
            tick();
            mem_rvalid = 1'b0;
            if (rvalid !== '0) begin
                o_rvalid = rvalid; o_rdata = rdata; o_wait = cyc; o_busy_end = busy; done = 1'b1;
            end else begin
                if (mem_req !== 1'b0 || gnt !== '0 || mem_we !== o_we || mem_addr !== o_addr ||
                    mem_wdata !== o_wdata || busy !== 1'b1) o_glitch++;
                if (cyc == lat) begin mem_rvalid = 1'b1; mem_rdata = resp; end
            end
        end
    endtask

    logic [N-1:0]  t_gnt, t_rv;
    logic          t_we, t_be;
    logic [AW-1:0] t_addr;
    logic [LW-1:0] t_wd, t_rd;
    int            t_wait, t_gl;

    task automatic test_reset();
        rsn = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick();
        tests++; if (gnt !== '0)       begin fails++; $display("FAIL reset_gnt got %b want 0", gnt); end
        tests++; if (rvalid !== '0)    begin fails++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
        tests++; if (rdata !== '0)     begin fails++; $display("FAIL reset_rdata got %h want 0", rdata); end
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        tests++; if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0)
            begin fails++; $display("FAIL reset_mem_bus got we=%b addr=%h want 0", mem_we, mem_addr); end
        tests++; if (busy !== 1'b0 || err !== 1'b0)
            begin fails++; $display("FAIL reset_status got busy=%b err=%b want 0 0", busy, err); end
        rsn = 1'b0;
        model_ptr = 0;
    endtask

    task automatic test_read_basic();
        logic [LW-1:0] pat;
        do_reset();
        pat = {16{8'hA5}};
        set_ch(0, 1'b0, 32'h100, '0);
        run_txn(2, pat, t_gnt, t_we, t_addr, t_wd, t_rv, t_rd, t_wait, t_gl, t_be);
        model_ptr = (0 + 1) % N;
        $display("[TB] read ch0 gnt=%b rvalid=%b wait=%0d", t_gnt, t_rv, t_wait);
        tests++; if (t_gnt !== 4'b0001) begin fails++; $display("FAIL read_gnt got %b want 0001", t_gnt); end
        tests++; if (t_we !== 1'b0 || t_addr !== 32'h100)
            begin fails++; $display("FAIL read_mem got we=%b addr=%h want 0 100", t_we, t_addr); end
        tests++; if (t_rv !== 4'b0001 || t_rd !== pat)
            begin fails++; $display("FAIL read_resp got rv=%b data=%h want 0001 %h", t_rv, t_rd, pat); end
        tests++; if (t_wait !== 3 || t_gl !== 0 || t_be !== 1'b0)
            begin fails++; $display("FAIL read_timing got wait=%0d glitch=%0d busy=%b want 3 0 0", t_wait, t_gl, t_be); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] want;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_ch(0, 1'b0, 32'h1000, '0);
            set_ch(1, 1'b0, 32'h2000, '0);
            want = onehot(model_winner(req));
            run_txn(1, {4{$urandom}}, t_gnt, t_we, t_addr, t_wd, t_rv, t_rd, t_wait, t_gl, t_be);
            if (RR) model_ptr = (model_winner(want) + 1) % N;
            $display("[TB] b2b %0d gnt=%b want=%b", i, t_gnt, want);
            tests++; if (t_gnt !== want || t_rv !== want)
                begin fails++; $display("FAIL b2b_gnt%0d got gnt=%b rv=%b want %b", i, t_gnt, t_rv, want); end
            tests++; if (t_wait !== 2 || t_gl !== 0)
                begin fails++; $display("FAIL b2b_timing%0d got wait=%0d glitch=%0d want 2 0", i, t_wait, t_gl); end
        end
        req = '0;
    endtask

    task automatic test_write();
        do_reset();
        set_ch(3, 1'b1, 32'hCAFE_0040, 128'hDEAD);
        run_txn(3, '0, t_gnt, t_we, t_addr, t_wd, t_rv, t_rd, t_wait, t_gl, t_be);
        $display("[TB] write ch3 gnt=%b we=%b wdata=%h rvalid=%b", t_gnt, t_we, t_wd, t_rv);
        tests++; if (t_gnt !== 4'b1000) begin fails++; $display("FAIL write_gnt got %b want 1000", t_gnt); end
        tests++; if (t_we !== 1'b1 || t_wd !== 128'hDEAD || t_addr !== 32'hCAFE_0040)
            begin fails++; $display("FAIL write_mem got we=%b wdata=%h want 1 dead", t_we, t_wd); end
        tests++; if (t_gl !== 0) begin fails++; $display("FAIL write_hold got %0d bad cycles want 0", t_gl); end
        tests++; if (t_rv !== 4'b1000 || t_wait !== 4)
            begin fails++; $display("FAIL write_ack got rv=%b wait=%0d want 1000 4", t_rv, t_wait); end
    endtask

    task automatic test_timeout();
        do_reset();
        set_ch(0, 1'b0, 32'h40, '0);
        run_txn(1, {4{32'h1357_9BDF}}, t_gnt, t_we, t_addr, t_wd, t_rv, t_rd, t_wait, t_gl, t_be);
        if (RR) model_ptr = 1;
        set_ch(2, 1'b0, 32'h80, '0);
        run_txn(-1, '0, t_gnt, t_we, t_addr, t_wd, t_rv, t_rd, t_wait, t_gl, t_be);
        if (RR) model_ptr = 3;
        $display("[TB] timeout ch2 rvalid=%b wait=%0d err=%b", t_rv, t_wait, err);
        tests++; if (t_rv !== 4'b0100 || t_rd !== '0)
            begin fails++; $display("FAIL timeout_resp got rv=%b data=%h want 0100 0", t_rv, t_rd); end
        tests++; if (t_wait !== TO + 1 || t_gl !== 0 || t_be !== 1'b0)
            begin fails++; $display("FAIL timeout_timing got wait=%0d glitch=%0d busy=%b want %0d 0 0", t_wait, t_gl, t_be, TO + 1); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL timeout_err got %b want 1", err); end
        set_ch(1, 1'b0, 32'hC0, '0);
        run_txn(1, 128'h77, t_gnt, t_we, t_addr, t_wd, t_rv, t_rd, t_wait, t_gl, t_be);
        tests++; if (t_rv !== 4'b0010 || t_rd !== 128'h77 || err !== 1'b1)
            begin fails++; $display("FAIL timeout_sticky got rv=%b err=%b want 0010 1", t_rv, err); end
        do_reset();
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL timeout_clear got %b want 0", err); end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        set_ch(1, 1'b1, 32'h1234, 128'hBEEF);
        tick();
        tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL rstwait_gnt got %b want 0010", gnt); end
        req = '0;
        tick();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rstwait_busy got %b want 1", busy); end
        rsn = 1'b1;
        tick();
        rsn = 1'b0;
        model_ptr = 0;
        tests++; if (gnt !== '0 || rvalid !== '0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
                     mem_addr !== '0 || mem_wdata !== '0 || busy !== 1'b0 || err !== 1'b0)
            begin fails++; $display("FAIL rstwait_outs got rv=%b we=%b addr=%h busy=%b want all 0", rvalid, mem_we, mem_addr, busy); end
        mem_rvalid = 1'b1; mem_rdata = {4{32'hFFFF_0000}};
        tick();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++; if (rvalid !== '0 || busy !== 1'b0 || rdata !== '0)
                begin fails++; $display("FAIL rstwait_stray%0d got rv=%b busy=%b want 0 0", i, rvalid, busy); end
            tick();
        end
        $display("[TB] reset in WAIT then stray response done");
    endtask

    task automatic test_issue_response();
        do_reset();
        set_ch(2, 1'b0, 32'h500, '0);
        run_txn(0, 128'h0123_4567_89AB_CDEF, t_gnt, t_we, t_addr, t_wd, t_rv, t_rd, t_wait, t_gl, t_be);
        $display("[TB] issue-cycle response rvalid=%b wait=%0d", t_rv, t_wait);
        tests++; if (t_rv !== 4'b0100 || t_rd !== 128'h0123_4567_89AB_CDEF || t_wait !== 1)
            begin fails++; $display("FAIL issue_resp got rv=%b wait=%0d want 0100 1", t_rv, t_wait); end
        tests++; if (t_be !== 1'b0) begin fails++; $display("FAIL issue_busy got %b want 0", t_be); end
    endtask

    task automatic test_random();
        int w, lat;
        logic          ew;
        logic [AW-1:0] ea;
        logic [LW-1:0] ed, resp;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            for (int c = 0; c < N; c++)
                if (!req[c] && $urandom_range(0, 1) == 1)
                    set_ch(c, 1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom, $urandom, $urandom});
            if (req == '0)
                set_ch(int'($urandom_range(0, N - 1)), 1'b0, $urandom, '0);
            w = model_winner(req);
            ew = we[w]; ea = addr[w*AW +: AW]; ed = wdata[w*LW +: LW];
            lat = int'($urandom_range(0, 3));
            resp = {$urandom, $urandom, $urandom, $urandom};
            run_txn(lat, resp, t_gnt, t_we, t_addr, t_wd, t_rv, t_rd, t_wait, t_gl, t_be);
            if (RR) model_ptr = (w + 1) % N;
            $display("[TB] rand %0d winner=%0d gnt=%b we=%b lat=%0d rvalid=%b", i, w, t_gnt, t_we, lat, t_rv);
            tests++; if (t_gnt !== onehot(w) || t_rv !== onehot(w))
                begin fails++; $display("FAIL rand_owner%0d got gnt=%b rv=%b want %b", i, t_gnt, t_rv, onehot(w)); end
            tests++; if (t_we !== ew || t_addr !== ea || (ew && t_wd !== ed))
                begin fails++; $display("FAIL rand_mem%0d got we=%b addr=%h want %b %h", i, t_we, t_addr, ew, ea); end
            tests++; if ((!ew && t_rd !== resp) || t_wait !== lat + 1 || t_gl !== 0)
                begin fails++; $display("FAIL rand_resp%0d got data=%h wait=%0d glitch=%0d want %h %0d 0", i, t_rd, t_wait, t_gl, resp, lat + 1); end
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_back_to_back();
        test_write();
        test_timeout();
        test_reset_in_wait();
        test_issue_response();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish before 200000");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/segre_mem_arbiter.md
# segre_mem_arbiter

Parametrised main-memory arbiter between the pipeline's cache controllers (instruction cache, data cache, store buffer, future prefetcher) and the single main-memory port. It generalises the fixed IC-over-DC select to NUM_CH requesters. It latches the winning request, holds ownership of the memory port until the response returns, and routes the response back to the owner. A watchdog flags a memory response that never arrives.

## Interface
- NUM_CH, 2: number of requesting channels, 2..8; channel 0 is the instruction cache.
- ADDR_W, 32: request address width.
- LINE_W, 128: cache-line data width.
- TIMEOUT, 255: maximum WAIT cycles before a timeout; must be ≥1.

- clk_i  in  1  clock, all logic on rising edge
- rsn_i  in  1  synchronous, active-high reset
- req_i  in  NUM_CH  per-channel request, held until granted
- we_i  in  NUM_CH  per-channel write (1) / read (0)
- addr_i  in  NUM_CH*ADDR_W  channel c at bits [c*ADDR_W +: ADDR_W]
- wdata_i  in  NUM_CH*LINE_W  channel c at bits [c*LINE_W +: LINE_W]
- gnt_o  out  NUM_CH  one-hot, one-cycle pulse: request accepted
- rvalid_o  out  NUM_CH  one-hot, one-cycle pulse: response for owner
- rdata_o  out  LINE_W  response data, valid with rvalid_o
- mem_req_o  out  1  one-cycle request pulse to memory
- mem_we_o  out  1  write flag to memory
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  LINE_W  memory write data
- mem_rvalid_i  in  1  memory response or write ack, one-cycle pulse
- mem_rdata_i  in  LINE_W  memory read data
- busy_o  out  1  state ≠ IDLE
- err_o  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any req_i bit is set, pick a winner w. Latch w, we_i[w], addr_i[w] and wdata_i[w] into the mem_* registers. Go to ISSUE. Otherwise stay in IDLE.
- ISSUE (exactly one cycle): gnt_o[w]=1, mem_req_o=1, then go to WAIT. If mem_rvalid_i is also 1 in this cycle, it is accepted as the response.
- WAIT: on mem_rvalid_i, register mem_rdata_i into rdata_o, pulse rvalid_o[w] in the next cycle, and go to IDLE.
- Writes follow the same flow; rvalid_o is the write ack, and rdata_o is don't-care for writes.
- Watchdog:
  - Counter is cleared on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT with no response, set err_o, pulse rvalid_o[w] with rdata_o=0, and go to IDLE.
  - err_o stays set until reset.
- A channel that drops req_i before being selected is simply not considered. A channel's req_i is ignored after its gnt_o until its rvalid_o.
- mem_addr_o, mem_we_o and mem_wdata_o hold their latched values from ISSUE through WAIT.
- Reset values: state IDLE, all outputs 0, round-robin pointer 0, watchdog counter 0, err_o 0.
- Reset in ISSUE or WAIT abandons the transaction. No rvalid_o is produced, and any later mem_rvalid_i seen in IDLE is ignored.

## Timing
- req_i sampled at edge k: gnt_o and mem_req_o are high in cycle k+1, and the FSM is in WAIT from k+2.
- mem_rvalid_i in cycle m: rvalid_o and rdata_o are valid in cycle m+1 and the FSM is in IDLE at m+1.
- Next grant is no earlier than m+2.
- Minimum turnaround is 3 cycles per transaction with 1-cycle memory latency.
- A channel holding req_i continuously waits at most NUM_CH-1 transactions in round-robin mode.

## Configuration
- SEGRE_ARB_ROUND_ROBIN_EN defined:
  - Winner is the first requesting channel at or after the pointer, searching upward with wrap-around.
  - The pointer is set to (w+1) mod NUM_CH on each grant.
- Not defined:
  - Fixed priority: the lowest requesting index wins, so IC beats DC, matching current behaviour.
  - No pointer register.

## Structure
- segre_pkg: arb_state_e (IDLE, ISSUE, WAIT), default constants for ADDR_W, LINE_W and TIMEOUT.
- Counter widths are derived locally with $clog2.
- One sub-module, segre_rr_picker: combinational. Inputs are the request vector and the pointer. Output is the one-hot winner plus an any-valid flag. With pointer tied to 0 it is the fixed-priority picker.

## Test plan
- NUM_CH=2, req_i=2'b01 read at addr 0x100, memory responds 2 cycles after mem_req_o with 0xA5 pattern:
  - gnt_o=01 at k+1.
  - rvalid_o=01 with that pattern one cycle after mem_rvalid_i.
- req_i=2'b11 held for both channels, back to back:
  - Round-robin: grants go 01, 10, 01.
  - Fixed priority: 01, 01, 01, and channel 1 is never granted while channel 0 requests.
- NUM_CH=4, write from channel 3 with wdata 0xDEAD:
  - mem_we_o=1 and mem_wdata_o=0xDEAD held until the ack.
  - rvalid_o=1000 after the ack.
- TIMEOUT=4, mem_rvalid_i never asserted:
  - err_o=1 after the 4th WAIT cycle, rvalid_o pulses for the owner with rdata_o=0, FSM returns to IDLE.
  - err_o stays set until rsn_i.
- rsn_i asserted for 1 cycle during WAIT, then a stray mem_rvalid_i:
  - All outputs return to 0, no rvalid_o pulse, busy_o=0.
- mem_rvalid_i asserted in the ISSUE cycle: response accepted, rvalid_o pulses in the next cycle.
